// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register in front of the 32-bit ALU.
// It accepts one RV32 instruction plus rs1/rs2 register-file reads per
// valid/ready handshake. It decodes the 3-bit ALU opcode and the immediate,
// holds them for one stage, and drives the ALU operands with EX/MEM and
// MEM/WB forwarding applied.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   flush                    squash held entry and any entry being accepted
//   in_valid/in_ready        upstream handshake
//   in_instr                 RV32 instruction word
//   in_rs1_data/in_rs2_data  register-file operand reads
//   exm_wen/exm_rd/exm_data  EX/MEM writeback (highest forwarding priority)
//   mwb_wen/mwb_rd/mwb_data  MEM/WB writeback
//   out_valid/out_ready      downstream handshake to the EX stage
//   alu_op, a, b             ALU opcode and operands (forwarded)
//   out_store_data           forwarded rs2 value, used by stores
//   out_rd                   destination register (0 when nothing is written)
//   out_illegal              unsupported encoding
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            exm_wen,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_wen,
  input  logic [4:0]      mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  // Decoded values for the incoming instruction
  logic [2:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_use_imm;
  logic [4:0]      dec_rd;
  logic            dec_ill;

  logic [XLEN-1:0] imm_i, imm_s, imm_shamt;

  assign imm_i     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_shamt = XLEN'(in_instr[24:20]);

  // Instruction decode: ALU opcode, immediate select, destination, legality
  always_comb begin
    dec_op      = ALU_ADD;
    dec_imm     = '0;
    dec_use_imm = 1'b0;
    dec_rd      = rd_f;
    dec_ill     = 1'b0;
    unique case (opcode)
      OPC_R: begin
        unique case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     dec_op = ALU_ADD;
            else if (funct7 == F7_ALT) dec_op = ALU_SUB;
            else                       dec_ill = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_ill = 1'b1;
          end
          3'b001: begin dec_op = ALU_SLL; dec_ill = (funct7 != F7_BASE); end
          3'b100: begin dec_op = ALU_XOR; dec_ill = (funct7 != F7_BASE); end
          3'b110: begin dec_op = ALU_OR;  dec_ill = (funct7 != F7_BASE); end
          3'b111: begin dec_op = ALU_AND; dec_ill = (funct7 != F7_BASE); end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_I: begin
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
        unique case (funct3)
          3'b000: dec_op = ALU_ADD;
          3'b100: dec_op = ALU_XOR;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          3'b001: begin
            dec_op  = ALU_SLL;
            dec_imm = imm_shamt;
            dec_ill = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec_imm = imm_shamt;
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_op      = ALU_ADD;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
      end
      OPC_STORE: begin
        dec_op      = ALU_ADD;
        dec_use_imm = 1'b1;
        dec_imm     = imm_s;
        dec_rd      = 5'd0;
      end
      OPC_BRANCH: begin
        dec_op = ALU_SUB;
        dec_rd = 5'd0;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal entries must not look like a real ALU op or register write
    if (dec_ill) begin
      dec_op      = ALU_ADD;
      dec_rd      = 5'd0;
      dec_use_imm = 1'b0;
      dec_imm     = '0;
    end
  end

  // Stored entry
  logic            valid_q,    valid_d;
  logic [2:0]      alu_op_q,   alu_op_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic            use_imm_q,  use_imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rd_q,       rd_d;
  logic            illegal_q,  illegal_d;

  logic load_c;

  assign in_ready = !valid_q || out_ready;
  // Flush wins over accept
  assign load_c   = in_valid && in_ready && !flush;

  // Next-state: hold on stall, replace on accept, drop on consume or flush
  always_comb begin
    valid_d    = valid_q;
    alu_op_d   = alu_op_q;
    imm_d      = imm_q;
    use_imm_d  = use_imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_d       = rd_q;
    illegal_d  = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
    end
    if (load_c) begin
      alu_op_d   = dec_op;
      imm_d      = dec_imm;
      use_imm_d  = dec_use_imm;
      rs1_d      = rs1_f;
      rs2_d      = rs2_f;
      rs1_data_d = in_rs1_data;
      rs2_data_d = in_rs2_data;
      rd_d       = dec_rd;
      illegal_d  = dec_ill;
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_op_q   <= 3'd0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_q       <= 5'd0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_op_q   <= alu_op_d;
      imm_q      <= imm_d;
      use_imm_q  <= use_imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
    end
  end

  // Forwarding: EX/MEM beats MEM/WB beats the stored read; x0 never forwards
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] raw,
    input logic            e_wen,
    input logic [4:0]      e_rd,
    input logic [XLEN-1:0] e_data,
    input logic            m_wen,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_data
  );
    if (idx != 5'd0 && e_wen && e_rd == idx)      return e_data;
    else if (idx != 5'd0 && m_wen && m_rd == idx) return m_data;
    else                                          return raw;
  endfunction

  logic [XLEN-1:0] rs1_fwd_c, rs2_fwd_c;

  assign rs1_fwd_c = fwd_sel(rs1_q, rs1_data_q, exm_wen, exm_rd, exm_data,
                             mwb_wen, mwb_rd, mwb_data);
  assign rs2_fwd_c = fwd_sel(rs2_q, rs2_data_q, exm_wen, exm_rd, exm_data,
                             mwb_wen, mwb_rd, mwb_data);

  assign out_valid      = valid_q;
  assign alu_op         = alu_op_q;
  assign out_rd         = rd_q;
  assign out_illegal    = illegal_q;
  assign a              = rs1_fwd_c;
  assign b              = use_imm_q ? imm_q : rs2_fwd_c;
  assign out_store_data = rs2_fwd_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases followed by a randomized handshake run,
// checked against a reference model of the decode and forwarding rules.
module tb_id_ex_stage;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        out_valid, out_ready;
  logic [2:0]  alu_op;
  logic [31:0] a, b, out_store_data;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  // Model of the held entry
  logic        m_valid;
  logic [31:0] m_instr, m_r1, m_r2;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .a(a), .b(b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set rules.
  // Base op per funct3; the funct7=0100000 variants (SUB, SRA) are base+1.
  function automatic void exp_dec(input logic [31:0] ins, output logic [2:0] op,
                                  output logic use_imm, output logic [31:0] imm,
                                  output logic [4:0] rd, output logic ill);
    logic [6:0] opc, f7;
    logic [2:0] f3, base;
    logic       base_ok, shift;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    case (f3)
      3'd0: base = 3'd0;
      3'd1: base = 3'd5;
      3'd4: base = 3'd4;
      3'd5: base = 3'd6;
      3'd6: base = 3'd3;
      3'd7: base = 3'd2;
      default: base = 3'd0;
    endcase
    base_ok = (f3 != 3'd2) && (f3 != 3'd3);
    shift   = (f3 == 3'd1) || (f3 == 3'd5);
    ill = 1'b1; op = 3'd0; use_imm = 1'b0; imm = 32'd0; rd = ins[11:7];
    if (opc == 7'h33) begin
      if (base_ok && f7 == 7'h00) begin ill = 1'b0; op = base; end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ill = 1'b0; op = base + 3'd1; end
    end else if (opc == 7'h13) begin
      use_imm = 1'b1;
      if (base_ok && !shift) begin
        ill = 1'b0; op = base; imm = 32'($signed(ins[31:20]));
      end else if (shift && f7 == 7'h00) begin
        ill = 1'b0; op = base; imm = 32'(ins[24:20]);
      end else if (f3 == 3'd5 && f7 == 7'h20) begin
        ill = 1'b0; op = 3'd7; imm = 32'(ins[24:20]);
      end
    end else if (opc == 7'h03) begin
      ill = 1'b0; use_imm = 1'b1; imm = 32'($signed(ins[31:20]));
    end else if (opc == 7'h23) begin
      ill = 1'b0; use_imm = 1'b1; rd = 5'd0;
      imm = 32'($signed({ins[31:25], ins[11:7]}));
    end else if (opc == 7'h63) begin
      ill = 1'b0; op = 3'd1; rd = 5'd0;
    end
    if (ill) begin op = 3'd0; rd = 5'd0; end
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] raw);
    if (r == 5'd0) return raw;
    if (exm_wen && exm_rd == r) return exm_data;
    if (mwb_wen && mwb_rd == r) return mwb_data;
    return raw;
  endfunction

  task automatic check_all(input string tag);
    logic [2:0]  op;
    logic        ui, ill;
    logic [31:0] imm, r2v;
    logic [4:0]  rd;
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
    if (m_valid) begin
      exp_dec(m_instr, op, ui, imm, rd, ill);
      r2v = fwd(m_instr[24:20], m_r2);
      chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
      chk({tag, "_op"},  32'(alu_op), 32'(op));
      chk({tag, "_rd"},  32'(out_rd), 32'(rd));
      chk({tag, "_a"},   a, fwd(m_instr[19:15], m_r1));
      if (!ill) begin
        chk({tag, "_b"},  b, ui ? imm : r2v);
        chk({tag, "_sd"}, out_store_data, r2v);
      end
    end
  endtask

  // One clock edge, with the model following the handshake rules
  task automatic tick();
    logic rdy;
    rdy = !m_valid || out_ready;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (rdy) begin
      if (in_valid) begin
        m_instr = in_instr; m_r1 = in_rs1_data; m_r2 = in_rs2_data;
      end
      m_valid = in_valid;
    end
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_instr = ins; in_rs1_data = r1; in_rs2_data = r2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic no_fwd();
    exm_wen = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
    mwb_wen = 1'b0; mwb_rd = 5'd0; mwb_data = 32'd0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    case ($urandom_range(0, 6))
      0:       opc = 7'h33;
      1, 2:    opc = 7'h13;
      3:       opc = 7'h03;
      4:       opc = 7'h23;
      5:       opc = 7'h63;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom), opc};
  endfunction

  logic [31:0] i_add, i_addi, i_srai, i_sw, i_sub, i_slt, i_bad;

  initial begin
    i_add  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    i_addi = {12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13};
    i_srai = {7'h20, 5'd4, 5'd1, 3'd5, 5'd1, 7'h13};
    i_sw   = {7'h00, 5'd2, 5'd1, 3'd2, 5'd8, 7'h23};
    i_sub  = {7'h20, 5'd1, 5'd1, 3'd0, 5'd4, 7'h33};
    i_slt  = {7'h00, 5'd3, 5'd2, 3'd2, 5'd1, 7'h33};
    i_bad  = {25'h0ABCDE, 7'h7F};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
    no_fwd();
    m_valid = 1'b0; m_instr = 32'd0; m_r1 = 32'd0; m_r2 = 32'd0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(i_add, 32'd5, 32'd7);
    check_all("add");
    chk("add_a_k", a, 32'd5);
    chk("add_b_k", b, 32'd7);
    chk("add_rd_k", 32'(out_rd), 32'd3);

    send(i_addi, 32'd9, 32'd9);
    check_all("addi");
    chk("addi_b_k", b, 32'hFFFF_FFFF);

    send(i_srai, 32'h8000_0000, 32'd0);
    check_all("srai");
    chk("srai_op_k", 32'(alu_op), 32'd7);
    chk("srai_b_k", b, 32'd4);

    send(i_sw, 32'h100, 32'hCAFE);
    check_all("sw");
    chk("sw_b_k", b, 32'd8);
    chk("sw_sd_k", out_store_data, 32'hCAFE);
    chk("sw_rd_k", 32'(out_rd), 32'd0);

    // Forwarding priority on SUB x4,x1,x1
    send(i_sub, 32'h55, 32'h55);
    exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'h10;
    mwb_wen = 1'b1; mwb_rd = 5'd1; mwb_data = 32'h20;
    #1;
    check_all("fwd_exm");
    chk("fwd_exm_a_k", a, 32'h10);
    chk("fwd_exm_b_k", b, 32'h10);
    exm_rd = 5'd0; #1;
    check_all("fwd_mwb");
    chk("fwd_mwb_a_k", a, 32'h20);
    mwb_rd = 5'd0; #1;
    check_all("fwd_none");
    chk("fwd_none_a_k", a, 32'h55);
    no_fwd();

    // Stall three cycles with a new entry waiting
    send(i_add, 32'd11, 32'd22);
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = i_sub; in_rs1_data = 32'd33; in_rs2_data = 32'd44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall");
      chk("stall_ready_k", 32'(in_ready), 32'd0);
      chk("stall_a_k", a, 32'd11);
    end
    exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'h77; #1;
    chk("stall_fwd_a", a, 32'h77);
    exm_data = 32'h78; #1;
    chk("stall_fwd_a2", a, 32'h78);
    no_fwd();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_all("stall_rel");
    chk("stall_rel_op_k", 32'(alu_op), 32'd1);
    chk("stall_rel_a_k", a, 32'd33);

    send(i_slt, 32'd1, 32'd2);
    check_all("slt");
    chk("slt_ill_k", 32'(out_illegal), 32'd1);
    send(i_bad, 32'd1, 32'd2);
    check_all("badopc");
    chk("badopc_ill_k", 32'(out_illegal), 32'd1);

    // Consume without accept
    tick();
    check_all("drain");

    // Flush beats accept
    send(i_add, 32'd1, 32'd2);
    in_valid = 1'b1; in_instr = i_sub; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_all("flush");
    chk("flush_valid_k", 32'(out_valid), 32'd0);

    // Reset while stalled
    send(i_add, 32'd3, 32'd4);
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    m_valid = 1'b0;
    chk("rstm_valid", 32'(out_valid), 32'd0);
    chk("rstm_ready", 32'(in_ready), 32'd1);
    chk("rstm_a", a, 32'd0);
    chk("rstm_b", b, 32'd0);
    chk("rstm_sd", out_store_data, 32'd0);
    chk("rstm_rd", 32'(out_rd), 32'd0);
    chk("rstm_op", 32'(alu_op), 32'd0);
    chk("rstm_ill", 32'(out_illegal), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized handshake and forwarding run
    for (int n = 0; n < 400; n++) begin
      in_valid    = 1'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      in_instr    = rand_instr();
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      exm_wen = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_data = $urandom;
      mwb_wen = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_data = $urandom;
      #1;
      check_all("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
